// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and segment constants for the result display
// Provides the converter state enum, the blank pattern and the active-low
// gfedcba segment table. No ports.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Indexed directly by a BCD nibble. Entries 10..15 cannot come out of a
  // valid double-dabble result, so they simply render as blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD nibble to active-low 7-segment decoder
// Ports:
//   nibble_i  BCD digit value
//   blank_i   force the digit dark (leading-zero blanking)
//   seg_o     active-low segments, bit order gfedcba (bit0 = a)
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - binary to decimal 7-segment display driver
// Converts value_i by iterative double-dabble (one shift per clock) whenever it
// differs from the last converted value, then registers blanked digits.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous reset, active-high
//   value_i  binary value to display
//   seg_o    DIGITS x 7 active-low segments, digit 0 least significant
//   busy_o   high while a conversion is in progress
//   done_o   one-cycle pulse on the cycle seg_o updates
module result_display
  import display_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WIDTH-1:0]    value_i,
  output logic [DIGITS*7-1:0] seg_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = DIGITS * 4;

  // "0" in the least significant digit, everything above dark.
  localparam logic [DIGITS*7-1:0] SEG_RESET = {{(DIGITS - 1){SEG_BLANK}}, SEG_TABLE[0]};

  // The largest input must fit in the available decimal digits.
  if ((64'd10 ** DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_param_check
    $error("result_display: DIGITS too small for WIDTH");
  end

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     last_q;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]     cnt_q;
  logic [DIGITS*7-1:0]  seg_q, seg_next;
  logic                 done_q;
  logic                 start;

  // Changes during a conversion are not latched; they are picked up by this
  // compare on the first cycle back in IDLE.
  assign start = (value_i != last_q);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CONVERT;
      ST_CONVERT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o = (state_q == ST_CONVERT) || (state_q == ST_DONE);
    done_o = done_q;
    seg_o  = seg_q;
  end

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[k*4 +: 4] >= 4'd5) begin
        bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
      end
    end
  end

  assign {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q  <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= SEG_RESET;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            last_q  <= value_i;
            shift_q <= value_i;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
          end
        end
        ST_CONVERT: begin
          bcd_q   <= bcd_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_DONE: begin
          seg_q  <= seg_next;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digit k is blank when it and every digit above it are zero; digit 0 always shows.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic blank;
    if (k == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = (bcd_q[BCD_W-1:k*4] == '0);
    end
    seg7_decoder u_dec (
      .nibble_i (bcd_q[k*4 +: 4]),
      .blank_i  (blank),
      .seg_o    (seg_next[k*7 +: 7])
    );
  end

endmodule
